// File: rtl/context_pkg.sv
// Shared definitions for the context fetch block: FSM encoding and default sizes.
package context_pkg;

  // Default geometry: one context word, memory address width, context pointer width.
  localparam int DEF_CTX_W = 32;
  localparam int DEF_AW    = 4;
  localparam int DEF_CP_W  = 16;

  // Fetch FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/context_fetch_if.sv
// Signal bundle between the host/upstream side (master) and the context fetch block (slave).
interface context_fetch_if
  import context_pkg::*;
#(
  parameter int CTX_W = DEF_CTX_W,
  parameter int AW    = DEF_AW,
  parameter int CP_W  = DEF_CP_W
) ();

  logic             start;
  logic [CP_W-1:0]  CP;
  logic             ld_we;
  logic [AW-1:0]    ld_addr;
  logic [CTX_W-1:0] ld_data;
  logic [AW:0]      cfg_len;
  logic [15:0]      cfg_iter;
  logic [CTX_W-1:0] ctx_out;
  logic [AW-1:0]    ctx_idx;
  logic             ctx_valid;
  logic [15:0]      iter_cnt;
  logic             done;
  logic             err;

  modport master (
    output start, CP, ld_we, ld_addr, ld_data, cfg_len, cfg_iter,
    input  ctx_out, ctx_idx, ctx_valid, iter_cnt, done, err
  );

  modport slave (
    input  start, CP, ld_we, ld_addr, ld_data, cfg_len, cfg_iter,
    output ctx_out, ctx_idx, ctx_valid, iter_cnt, done, err
  );

endinterface

// File: rtl/context_ram.sv
// Simple dual-port context memory: one host write port, one synchronous read port.
module context_ram #(
  parameter int W  = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  // NOTE: the array and its read register carry no reset, so they map onto plain RAM.
  logic [W-1:0] mem [2**AW];

  // Host write port.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment keeps every flop updating from pre-edge values.
    if (we) mem[waddr] <= wdata;
  end

  // Read port, one cycle of latency; data holds while re is low.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/context_fetch.sv
// Follows the upstream context pointer and presents one registered context word per step.
module context_fetch
  import context_pkg::*;
#(
  parameter int CTX_W = DEF_CTX_W,
  parameter int AW    = DEF_AW,
  parameter int CP_W  = DEF_CP_W
) (
  input logic            CLK,
  input logic            RST,
  context_fetch_if.slave bus
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_t           state, state_d;
  logic [AW:0]      len;
  logic [15:0]      iter;
  logic [CP_W-1:0]  prev_cp;
  logic [AW-1:0]    idx;
  logic [15:0]      iter_cnt;
  logic             ctx_valid;
  logic             done;
  logic             err;
  logic             loaded;
  logic [CTX_W-1:0] ram_q;

  // Step checker and index arithmetic.
  logic            is_step, is_stall, wrap, len_ok;
  logic [AW-1:0]   next_idx;
  logic [15:0]     iter_inc;

  assign is_step  = (bus.CP == prev_cp + CP_W'(1));
  assign is_stall = (bus.CP == prev_cp);
  assign wrap     = ({1'b0, idx} == len - (AW+1)'(1));
  assign next_idx = wrap ? '0 : idx + AW'(1);
  assign iter_inc = iter_cnt + 16'd1;
  assign len_ok   = (bus.cfg_len != '0) && (bus.cfg_len <= DEPTH);

  // FSM control strobes.
  logic          launch, advance, finish, fault, drop, leave_done, set_err, rd_en;
  logic [AW-1:0] rd_addr;

  context_ram #(.W(CTX_W), .AW(AW)) u_ram (
    .clk   (CLK),
    .we    (bus.ld_we && (state == ST_IDLE)),
    .waddr (bus.ld_addr),
    .wdata (bus.ld_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next-state and control decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state;
    launch     = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    fault      = 1'b0;
    drop       = 1'b0;
    leave_done = 1'b0;
    set_err    = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (len_ok) begin
            state_d = ST_RUN;
            launch  = 1'b1;
            rd_en   = 1'b1;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      ST_RUN: begin
        set_err = bus.ld_we;
        if (!bus.start) begin
          state_d = ST_IDLE;
          drop    = 1'b1;
        end else if (is_step) begin
          if (wrap && (iter != '0) && (iter_inc == iter)) begin
            state_d = ST_DONE;
            finish  = 1'b1;
          end else begin
            advance = 1'b1;
            rd_en   = 1'b1;
            rd_addr = next_idx;
          end
        end else if (!is_stall) begin
          state_d = ST_DONE;
          fault   = 1'b1;
          set_err = 1'b1;
        end
      end
      ST_DONE: begin
        set_err = bus.ld_we;
        if (!bus.start) begin
          state_d    = ST_IDLE;
          leave_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Program latches, index/iteration counters and status flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      len       <= '0;
      iter      <= '0;
      prev_cp   <= '0;
      idx       <= '0;
      iter_cnt  <= '0;
      ctx_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      loaded    <= 1'b0;
    end else begin
      if (launch) begin
        len       <= bus.cfg_len;
        iter      <= bus.cfg_iter;
        prev_cp   <= bus.CP;
        idx       <= '0;
        iter_cnt  <= '0;
        ctx_valid <= 1'b1;
        loaded    <= 1'b1;
      end
      if (advance) begin
        prev_cp <= bus.CP;
        idx     <= next_idx;
        if (wrap) iter_cnt <= iter_inc;
      end
      if (finish) begin
        prev_cp   <= bus.CP;
        iter_cnt  <= iter_inc;
        ctx_valid <= 1'b0;
        done      <= 1'b1;
      end
      if (fault || drop) ctx_valid <= 1'b0;
      if (leave_done)    done      <= 1'b0;
      if (launch)        err       <= 1'b0;
      else if (set_err)  err       <= 1'b1;
    end
  end

  // The RAM read register has no reset; mask it until the first fetch after reset.
  assign bus.ctx_out   = loaded ? ram_q : '0;
  assign bus.ctx_idx   = idx;
  assign bus.ctx_valid = ctx_valid;
  assign bus.iter_cnt  = iter_cnt;
  assign bus.done      = done;
  assign bus.err       = err;

endmodule

// File: tb/tb_context_fetch.sv
// Scoreboard bench for context_fetch: tasks push expected outputs, a monitor pops and compares.
module tb_context_fetch;
  import context_pkg::*;

  localparam int CTX_W = 32;
  localparam int AW    = 4;
  localparam int CP_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  context_fetch_if #(.CTX_W(CTX_W), .AW(AW), .CP_W(CP_W)) bus ();

  context_fetch #(.CTX_W(CTX_W), .AW(AW), .CP_W(CP_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        valid;
    logic [15:0] iter;
    logic        done;
    logic        err;
    logic [95:0] tag;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [95:0] cur_tag = "init";

  // Expected memory image loaded by the host.
  function automatic logic [31:0] word(input int i);
    return 32'(32'hA0 + i);
  endfunction

  task automatic push(input logic [31:0] d, input logic [3:0] i, input logic v,
                      input logic [15:0] it, input logic dn, input logic e);
    exp_t x;
    x.data = d; x.idx = i; x.valid = v; x.iter = it; x.done = dn; x.err = e; x.tag = cur_tag;
    exp_q.push_back(x);
  endtask

  // Inputs change on the falling edge so they are stable for the next rising edge.
  task automatic drive(input logic s, input logic [15:0] cp, input logic we = 1'b0,
                       input logic [3:0] wa = '0, input logic [31:0] wd = '0);
    @(negedge clk);
    bus.start   = s;
    bus.CP      = cp;
    bus.ld_we   = we;
    bus.ld_addr = wa;
    bus.ld_data = wd;
  endtask

  // Monitor: after each rising edge, compare outputs against the oldest expectation.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      if (bus.ctx_out !== mon_e.data) begin
        n_bad++; $display("FAIL %0s ctx_out got %h want %h", mon_e.tag, bus.ctx_out, mon_e.data);
      end
      n_cmp++;
      if (bus.ctx_idx !== mon_e.idx) begin
        n_bad++; $display("FAIL %0s ctx_idx got %0d want %0d", mon_e.tag, bus.ctx_idx, mon_e.idx);
      end
      n_cmp++;
      if (bus.ctx_valid !== mon_e.valid) begin
        n_bad++; $display("FAIL %0s ctx_valid got %b want %b", mon_e.tag, bus.ctx_valid, mon_e.valid);
      end
      n_cmp++;
      if (bus.iter_cnt !== mon_e.iter) begin
        n_bad++; $display("FAIL %0s iter_cnt got %0d want %0d", mon_e.tag, bus.iter_cnt, mon_e.iter);
      end
      n_cmp++;
      if (bus.done !== mon_e.done) begin
        n_bad++; $display("FAIL %0s done got %b want %b", mon_e.tag, bus.done, mon_e.done);
      end
      n_cmp++;
      if (bus.err !== mon_e.err) begin
        n_bad++; $display("FAIL %0s err got %b want %b", mon_e.tag, bus.err, mon_e.err);
      end
    end
  end

  task automatic test_reset();
    cur_tag = "reset";
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.ctx_out !== 32'h0)   begin n_bad++; $display("FAIL reset ctx_out got %h want 0", bus.ctx_out); end
    n_cmp++; if (bus.ctx_idx !== 4'h0)    begin n_bad++; $display("FAIL reset ctx_idx got %0d want 0", bus.ctx_idx); end
    n_cmp++; if (bus.ctx_valid !== 1'b0)  begin n_bad++; $display("FAIL reset ctx_valid got %b want 0", bus.ctx_valid); end
    n_cmp++; if (bus.iter_cnt !== 16'h0)  begin n_bad++; $display("FAIL reset iter_cnt got %0d want 0", bus.iter_cnt); end
    n_cmp++; if (bus.done !== 1'b0)       begin n_bad++; $display("FAIL reset done got %b want 0", bus.done); end
    n_cmp++; if (bus.err !== 1'b0)        begin n_bad++; $display("FAIL reset err got %b want 0", bus.err); end
    rst = 1'b0;
  endtask

  task automatic test_load();
    cur_tag = "load";
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'd0, 1'b1, 4'(i), word(i));
      push(32'h0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b0);
    end
    drive(1'b0, 16'd0);
    push(32'h0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic test_sequence();
    cur_tag = "sequence";
    bus.cfg_len = 5'd4; bus.cfg_iter = 16'd2;
    drive(1'b1, 16'd0);
    push(word(0), 4'd0, 1'b1, 16'd0, 1'b0, 1'b0);
    for (int k = 1; k < 8; k++) begin
      drive(1'b1, 16'(k));
      push(word(k % 4), 4'(k % 4), 1'b1, 16'(k / 4), 1'b0, 1'b0);
    end
    drive(1'b1, 16'd8);
    push(word(3), 4'd3, 1'b0, 16'd2, 1'b1, 1'b0);
    drive(1'b1, 16'd9);
    push(word(3), 4'd3, 1'b0, 16'd2, 1'b1, 1'b0);
    drive(1'b0, 16'd9);
    push(word(3), 4'd3, 1'b0, 16'd2, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    cur_tag = "stall";
    bus.cfg_len = 5'd4; bus.cfg_iter = 16'd0;
    drive(1'b1, 16'd100); push(word(0), 4'd0, 1'b1, 16'd0, 1'b0, 1'b0);
    drive(1'b1, 16'd101); push(word(1), 4'd1, 1'b1, 16'd0, 1'b0, 1'b0);
    drive(1'b1, 16'd102); push(word(2), 4'd2, 1'b1, 16'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 16'd102); push(word(2), 4'd2, 1'b1, 16'd0, 1'b0, 1'b0);
    end
    drive(1'b1, 16'd103); push(word(3), 4'd3, 1'b1, 16'd0, 1'b0, 1'b0);
    drive(1'b0, 16'd103); push(word(3), 4'd3, 1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic test_fault();
    cur_tag = "cp_jump";
    bus.cfg_len = 5'd4; bus.cfg_iter = 16'd0;
    drive(1'b1, 16'd3);  push(word(0), 4'd0, 1'b1, 16'd0, 1'b0, 1'b0);
    drive(1'b1, 16'd4);  push(word(1), 4'd1, 1'b1, 16'd0, 1'b0, 1'b0);
    drive(1'b1, 16'd5);  push(word(2), 4'd2, 1'b1, 16'd0, 1'b0, 1'b0);
    drive(1'b1, 16'd9);  push(word(2), 4'd2, 1'b0, 16'd0, 1'b0, 1'b1);
    drive(1'b1, 16'd10); push(word(2), 4'd2, 1'b0, 16'd0, 1'b0, 1'b1);
    drive(1'b0, 16'd10); push(word(2), 4'd2, 1'b0, 16'd0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    cur_tag = "async_rst";
    bus.cfg_len = 5'd4; bus.cfg_iter = 16'd0;
    drive(1'b1, 16'd0); push(word(0), 4'd0, 1'b1, 16'd0, 1'b0, 1'b0);
    drive(1'b1, 16'd1); push(word(1), 4'd1, 1'b1, 16'd0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    bus.start = 1'b0;
    #1;
    n_cmp++; if (bus.ctx_out !== 32'h0)  begin n_bad++; $display("FAIL async_rst ctx_out got %h want 0", bus.ctx_out); end
    n_cmp++; if (bus.ctx_idx !== 4'h0)   begin n_bad++; $display("FAIL async_rst ctx_idx got %0d want 0", bus.ctx_idx); end
    n_cmp++; if (bus.ctx_valid !== 1'b0) begin n_bad++; $display("FAIL async_rst ctx_valid got %b want 0", bus.ctx_valid); end
    n_cmp++; if (bus.iter_cnt !== 16'h0) begin n_bad++; $display("FAIL async_rst iter_cnt got %0d want 0", bus.iter_cnt); end
    n_cmp++; if (bus.done !== 1'b0)      begin n_bad++; $display("FAIL async_rst done got %b want 0", bus.done); end
    n_cmp++; if (bus.err !== 1'b0)       begin n_bad++; $display("FAIL async_rst err got %b want 0", bus.err); end
    @(negedge clk);
    rst = 1'b0;
    cur_tag = "mem_keep";
    bus.cfg_len = 5'd4; bus.cfg_iter = 16'd1;
    drive(1'b1, 16'd0);
    push(word(0), 4'd0, 1'b1, 16'd0, 1'b0, 1'b0);
    for (int k = 1; k < 4; k++) begin
      drive(1'b1, 16'(k));
      push(word(k), 4'(k), 1'b1, 16'd0, 1'b0, 1'b0);
    end
    drive(1'b1, 16'd4); push(word(3), 4'd3, 1'b0, 16'd1, 1'b1, 1'b0);
    drive(1'b0, 16'd4); push(word(3), 4'd3, 1'b0, 16'd1, 1'b0, 1'b0);
  endtask

  task automatic test_len1_wrap();
    cur_tag = "len1_wrap";
    bus.cfg_len = 5'd1; bus.cfg_iter = 16'd0;
    drive(1'b1, 16'hFFFE); push(word(0), 4'd0, 1'b1, 16'd0, 1'b0, 1'b0);
    drive(1'b1, 16'hFFFF); push(word(0), 4'd0, 1'b1, 16'd1, 1'b0, 1'b0);
    drive(1'b1, 16'h0000); push(word(0), 4'd0, 1'b1, 16'd2, 1'b0, 1'b0);
    drive(1'b1, 16'h0001); push(word(0), 4'd0, 1'b1, 16'd3, 1'b0, 1'b0);
    drive(1'b0, 16'h0001); push(word(0), 4'd0, 1'b0, 16'd3, 1'b0, 1'b0);
  endtask

  task automatic test_ld_in_run();
    cur_tag = "ld_in_run";
    bus.cfg_len = 5'd4; bus.cfg_iter = 16'd0;
    drive(1'b1, 16'd0); push(word(0), 4'd0, 1'b1, 16'd0, 1'b0, 1'b0);
    drive(1'b1, 16'd1, 1'b1, 4'd2, 32'hDEAD_BEEF);
    push(word(1), 4'd1, 1'b1, 16'd0, 1'b0, 1'b1);
    drive(1'b1, 16'd2); push(word(2), 4'd2, 1'b1, 16'd0, 1'b0, 1'b1);
    drive(1'b0, 16'd2); push(word(2), 4'd2, 1'b0, 16'd0, 1'b0, 1'b1);
    cur_tag = "mem_intact";
    bus.cfg_len = 5'd3; bus.cfg_iter = 16'd1;
    drive(1'b1, 16'd50); push(word(0), 4'd0, 1'b1, 16'd0, 1'b0, 1'b0);
    drive(1'b1, 16'd51); push(word(1), 4'd1, 1'b1, 16'd0, 1'b0, 1'b0);
    drive(1'b1, 16'd52); push(word(2), 4'd2, 1'b1, 16'd0, 1'b0, 1'b0);
    drive(1'b1, 16'd53); push(word(2), 4'd2, 1'b0, 16'd1, 1'b1, 1'b0);
    drive(1'b0, 16'd53); push(word(2), 4'd2, 1'b0, 16'd1, 1'b0, 1'b0);
  endtask

  task automatic test_bad_len();
    cur_tag = "len_zero";
    bus.cfg_len = 5'd0; bus.cfg_iter = 16'd0;
    drive(1'b1, 16'd60); push(word(2), 4'd2, 1'b0, 16'd1, 1'b0, 1'b1);
    drive(1'b1, 16'd61); push(word(2), 4'd2, 1'b0, 16'd1, 1'b0, 1'b1);
    drive(1'b0, 16'd61); push(word(2), 4'd2, 1'b0, 16'd1, 1'b0, 1'b1);
    cur_tag = "len2_run";
    bus.cfg_len = 5'd2; bus.cfg_iter = 16'd1;
    drive(1'b1, 16'd7); push(word(0), 4'd0, 1'b1, 16'd0, 1'b0, 1'b0);
    drive(1'b1, 16'd8); push(word(1), 4'd1, 1'b1, 16'd0, 1'b0, 1'b0);
    drive(1'b1, 16'd9); push(word(1), 4'd1, 1'b0, 16'd1, 1'b1, 1'b0);
    drive(1'b0, 16'd9); push(word(1), 4'd1, 1'b0, 16'd1, 1'b0, 1'b0);
    cur_tag = "len_17";
    bus.cfg_len = 5'd17;
    drive(1'b1, 16'd9); push(word(1), 4'd1, 1'b0, 16'd1, 1'b0, 1'b1);
    drive(1'b0, 16'd9); push(word(1), 4'd1, 1'b0, 16'd1, 1'b0, 1'b1);
  endtask

  // Bound on total run time.
  initial begin
    #100000;
    $display("FAIL watchdog expired with %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.CP = '0; bus.ld_we = 1'b0; bus.ld_addr = '0;
    bus.ld_data = '0; bus.cfg_len = '0; bus.cfg_iter = '0;
    test_reset();
    test_load();
    test_sequence();
    test_stall();
    test_fault();
    test_async_reset();
    test_len1_wrap();
    test_ld_in_run();
    test_bad_len();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL drain pending got %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
